// File: rtl/legv8_pkg.sv
// Shared LEGv8 encodings, FSM states and opcode classes
// for the single-cycle and multicycle controllers.
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SE_NONE = 2'b00;
  localparam logic [1:0] SE_D    = 2'b01;
  localparam logic [1:0] SE_B    = 2'b10;
  localparam logic [1:0] SE_CB   = 2'b11;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  typedef enum logic [2:0] {
    RTYPE, LOAD, STORE, CBZ, BR, ILL
  } opclass_t;

  function automatic logic [1:0] signop_of(
    input opclass_t c
  );
    logic [1:0] s;
    s = SE_NONE;
    unique case (c)
      LOAD, STORE: s = SE_D;
      BR:          s = SE_B;
      CBZ:         s = SE_CB;
      default:     s = SE_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/opcode_classify.sv
// Maps an 11-bit LEGv8 opcode to its class and ALU op.
// Pure combinational; shared with the single-cycle control.
module opcode_classify
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output opclass_t    opclass,
  output logic [3:0]  aluop
);

  always_comb begin
    opclass = ILL;
    aluop   = ALU_ADD;
    unique case (1'b1)
      opcode == OP_LDUR: opclass = LOAD;
      opcode == OP_STUR: opclass = STORE;
      opcode == OP_ADD: begin
        opclass = RTYPE;
        aluop   = ALU_ADD;
      end
      opcode == OP_SUB: begin
        opclass = RTYPE;
        aluop   = ALU_SUB;
      end
      opcode == OP_AND: begin
        opclass = RTYPE;
        aluop   = ALU_AND;
      end
      opcode == OP_ORR: begin
        opclass = RTYPE;
        aluop   = ALU_ORR;
      end
      opcode[10:3] == OP_CBZ: begin
        opclass = CBZ;
        aluop   = ALU_PASSB;
      end
      opcode[10:5] == OP_B: opclass = BR;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 sequencer: one shared memory port,
// FETCH/DECODE/EXEC/MEM/WB steps and retired-count.
module multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             irwrite,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             mem2reg,
  output logic             regwrite,
  output logic [3:0]       aluop,
  output logic [1:0]       signop,
  output logic             pcwrite,
  output logic             pcsrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q;
  opclass_t         cls_q;
  logic [3:0]       alu_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  opclass_t   fetch_cls;
  logic [3:0] fetch_alu;

  opcode_classify u_cls (
    .opcode  (opcode),
    .opclass (fetch_cls),
    .aluop   (fetch_alu)
  );

  // ALU selects stay up past EXEC so the address/result
  // seen by memory and writeback remain valid.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = 1'b0;
    irwrite  = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    regwrite = 1'b0;
    aluop    = ALU_AND;
    signop   = SE_NONE;
    pcwrite  = 1'b0;
    pcsrc    = 1'b0;
    if (!reset) begin
      if (state_q != FETCH && state_q != TRAP) begin
        reg2loc = (cls_q == STORE) || (cls_q == CBZ);
        signop  = signop_of(cls_q);
      end
      unique case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          irwrite = mem_ready;
        end
        EXEC: begin
          unique case (cls_q)
            RTYPE: aluop = alu_q;
            LOAD, STORE: begin
              alusrc = 1'b1;
              aluop  = ALU_ADD;
            end
            CBZ: begin
              aluop   = ALU_PASSB;
              pcwrite = 1'b1;
              pcsrc   = zero;
            end
            BR: begin
              pcwrite = 1'b1;
              pcsrc   = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (cls_q == STORE);
          alusrc  = 1'b1;
          aluop   = ALU_ADD;
          pcwrite = (cls_q == STORE) && mem_ready;
        end
        WB: begin
          regwrite = 1'b1;
          mem2reg  = (cls_q == LOAD);
          alusrc   = (cls_q == LOAD);
          aluop    = (cls_q == LOAD) ? ALU_ADD : alu_q;
          pcwrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q && !reset;
  assign instret = reset ? '0 : cnt_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= FETCH;
      cls_q     <= ILL;
      alu_q     <= ALU_ADD;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (pcwrite)
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      unique case (state_q)
        FETCH: begin
          if (mem_ready) begin
            cls_q <= fetch_cls;
            alu_q <= fetch_alu;
            if (fetch_cls == ILL) begin
              state_q   <= TRAP;
              illegal_q <= 1'b1;
            end else begin
              state_q <= DECODE;
            end
          end
        end
        DECODE: state_q <= EXEC;
        EXEC: begin
          unique case (cls_q)
            RTYPE:       state_q <= WB;
            LOAD, STORE: state_q <= MEM;
            default:     state_q <= FETCH;
          endcase
        end
        MEM: begin
          if (mem_ready)
            state_q <= (cls_q == STORE) ? FETCH : WB;
        end
        WB:      state_q <= FETCH;
        TRAP:    state_q <= TRAP;
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + random bench for multicycle_ctrl against a
// per-instruction cycle-sequence model.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, mem_sel, irwrite;
  logic        reg2loc, alusrc, mem2reg, regwrite;
  logic [3:0]  aluop;
  logic [1:0]  signop;
  logic        pcwrite, pcsrc, illegal;
  logic [31:0] instret;

  logic        b_req, b_we, b_sel, b_irw;
  logic        b_r2l, b_asrc, b_m2r, b_rw;
  logic [3:0]  b_aluop;
  logic [1:0]  b_signop;
  logic        b_pcw, b_pcs, b_ill;
  logic [1:0]  instret2;

  multicycle_ctrl dut (
    .CLK(CLK), .reset(reset), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .irwrite(irwrite),
    .reg2loc(reg2loc), .alusrc(alusrc),
    .mem2reg(mem2reg), .regwrite(regwrite),
    .aluop(aluop), .signop(signop),
    .pcwrite(pcwrite), .pcsrc(pcsrc),
    .illegal(illegal), .instret(instret)
  );

  multicycle_ctrl #(.CNT_W(2)) dut2 (
    .CLK(CLK), .reset(reset), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_req), .mem_we(b_we),
    .mem_sel(b_sel), .irwrite(b_irw),
    .reg2loc(b_r2l), .alusrc(b_asrc),
    .mem2reg(b_m2r), .regwrite(b_rw),
    .aluop(b_aluop), .signop(b_signop),
    .pcwrite(b_pcw), .pcsrc(b_pcs),
    .illegal(b_ill), .instret(instret2)
  );

  always #5 CLK = ~CLK;

  localparam int F_ILL = 0, F_PCS = 1, F_PCW = 2;
  localparam int F_SE = 3, F_ALU = 5, F_RW = 9;
  localparam int F_M2R = 10, F_ASRC = 11, F_R2L = 12;
  localparam int F_IRW = 13, F_SEL = 14, F_WE = 15;
  localparam int F_REQ = 16;

  localparam int K_R = 0, K_LD = 1, K_ST = 2;
  localparam int K_CBZ = 3, K_B = 4, K_ILL = 5;

  logic [16:0] obs;
  assign obs = {mem_req, mem_we, mem_sel, irwrite,
                reg2loc, alusrc, mem2reg, regwrite,
                aluop, signop, pcwrite, pcsrc, illegal};

  logic [16:0]     ex, care;
  int              total = 0;
  int              bad = 0;
  longint unsigned nret = 0;

  function automatic int kind(input logic [10:0] op);
    if (op == 11'h7C2) return K_LD;
    if (op == 11'h7C0) return K_ST;
    if (op == 11'h458 || op == 11'h658 ||
        op == 11'h450 || op == 11'h550) return K_R;
    if (op[10:3] == 8'hB4) return K_CBZ;
    if (op[10:5] == 6'h05) return K_B;
    return K_ILL;
  endfunction

  function automatic int rop(input logic [10:0] op);
    if (op == 11'h658) return 6;
    if (op == 11'h450) return 0;
    if (op == 11'h550) return 1;
    return 2;
  endfunction

  // full=1: every output checked; else only the
  // enables that must be zero unless raised below
  task automatic begin_exp(input bit full);
    ex = '0;
    care = '0;
    if (full) care = '1;
    else begin
      care[F_REQ] = 1'b1;
      care[F_WE]  = 1'b1;
      care[F_IRW] = 1'b1;
      care[F_RW]  = 1'b1;
      care[F_PCW] = 1'b1;
      care[F_ILL] = 1'b1;
    end
  endtask

  task automatic set_f(input int lo, input int w,
                       input int v);
    for (int b = 0; b < w; b++) begin
      ex[lo+b]   = v[b];
      care[lo+b] = 1'b1;
    end
  endtask

  task automatic drive(input logic rdy,
                       input logic [10:0] op,
                       input int z);
    opcode    = op;
    mem_ready = rdy;
    zero      = (z < 0) ? 1'($urandom) : z[0];
  endtask

  task automatic rnd_drive(input int z);
    drive(1'($urandom), 11'($urandom), z);
  endtask

  task automatic tick(input string tag);
    logic [16:0] o;
    @(negedge CLK);
    o = obs;
    total++;
    assert ((o & care) === (ex & care)) else begin
      bad++;
      $error("FAIL %s: ctrl observed=%05h expected=%05h",
             tag, o & care, ex & care);
    end
    total++;
    assert (instret === 32'(nret)) else begin
      bad++;
      $error("FAIL %s_instret: observed=%0d expected=%0d",
             tag, instret, 32'(nret));
    end
    total++;
    assert (instret2 === 2'(nret)) else begin
      bad++;
      $error("FAIL %s_wrap2: observed=%0d expected=%0d",
             tag, instret2, 2'(nret));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rnd_drive(-1);
    nret = 0;
    begin_exp(1'b1);
    tick("reset");
    reset = 1'b0;
  endtask

  // abort >= 0: reset after that many MEM wait cycles
  task automatic run_instr(input logic [10:0] op,
                           input int fw, input int mw,
                           input int z, input int abort);
    int k;
    k = kind(op);
    for (int i = 0; i < fw; i++) begin
      drive(1'b0, 11'($urandom), z);
      begin_exp(1'b1);
      set_f(F_REQ, 1, 1);
      tick("fetch_wait");
    end
    drive(1'b1, op, z);
    begin_exp(1'b1);
    set_f(F_REQ, 1, 1);
    set_f(F_IRW, 1, 1);
    tick("fetch");
    if (k == K_ILL) return;

    rnd_drive(z);
    begin_exp(1'b0);
    set_f(F_R2L, 1, int'(k == K_ST || k == K_CBZ));
    case (k)
      K_LD, K_ST: set_f(F_SE, 2, 1);
      K_B:        set_f(F_SE, 2, 2);
      K_CBZ:      set_f(F_SE, 2, 3);
      default:    ;
    endcase
    tick("decode");

    rnd_drive(z);
    begin_exp(1'b0);
    case (k)
      K_R: begin
        set_f(F_ASRC, 1, 0);
        set_f(F_ALU, 4, rop(op));
      end
      K_LD, K_ST: begin
        set_f(F_ASRC, 1, 1);
        set_f(F_ALU, 4, 2);
      end
      K_CBZ: begin
        set_f(F_ALU, 4, 7);
        set_f(F_PCW, 1, 1);
        set_f(F_PCS, 1, int'(zero));
      end
      default: begin
        set_f(F_PCW, 1, 1);
        set_f(F_PCS, 1, 1);
      end
    endcase
    tick("exec");
    if (k == K_CBZ || k == K_B) begin
      nret++;
      return;
    end

    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mw; i++) begin
        if (abort == i) begin
          do_reset();
          return;
        end
        drive(1'b0, 11'($urandom), z);
        begin_exp(1'b0);
        set_f(F_REQ, 1, 1);
        set_f(F_SEL, 1, 1);
        set_f(F_WE, 1, int'(k == K_ST));
        tick("mem_wait");
      end
      drive(1'b1, 11'($urandom), z);
      begin_exp(1'b0);
      set_f(F_REQ, 1, 1);
      set_f(F_SEL, 1, 1);
      set_f(F_WE, 1, int'(k == K_ST));
      if (k == K_ST) begin
        set_f(F_PCW, 1, 1);
        set_f(F_PCS, 1, 0);
      end
      tick("mem");
      if (k == K_ST) begin
        nret++;
        return;
      end
    end

    rnd_drive(z);
    begin_exp(1'b0);
    set_f(F_RW, 1, 1);
    set_f(F_M2R, 1, int'(k == K_LD));
    set_f(F_PCW, 1, 1);
    set_f(F_PCS, 1, 0);
    tick("wb");
    nret++;
  endtask

  function automatic logic [10:0] pick_op(input int s);
    logic [10:0] o;
    case (s)
      0: o = 11'h458;
      1: o = 11'h658;
      2: o = 11'h450;
      3: o = 11'h550;
      4: o = 11'h7C2;
      5: o = 11'h7C0;
      6: o = {8'hB4, 3'($urandom)};
      default: o = {6'h05, 5'($urandom)};
    endcase
    return o;
  endfunction

  initial begin
    do_reset();
    run_instr(11'h458, 0, 0, -1, -1);
    run_instr(11'h7C2, 0, 3, -1, -1);
    run_instr(11'h5A3, 0, 0, 1, -1);
    run_instr(11'h5A6, 0, 0, 0, -1);
    run_instr(11'h7C0, 1, 0, -1, -1);
    run_instr(11'h0A9, 0, 0, -1, -1);
    run_instr(11'h658, 2, 0, -1, -1);
    run_instr(11'h450, 0, 0, -1, -1);
    run_instr(11'h550, 1, 0, -1, -1);
    run_instr(11'h7C0, 0, 2, -1, -1);

    for (int n = 0; n < 50; n++)
      run_instr(pick_op($urandom_range(0, 7)),
                $urandom_range(0, 2),
                $urandom_range(0, 2), -1, -1);

    run_instr(11'h000, 0, 0, -1, -1);
    for (int i = 0; i < 6; i++) begin
      rnd_drive(-1);
      begin_exp(1'b1);
      set_f(F_ILL, 1, 1);
      tick("trap");
    end
    do_reset();
    run_instr(11'h458, 0, 0, -1, -1);

    run_instr(11'h7C2, 0, 3, -1, 1);
    run_instr(11'h7C0, 0, 3, -1, 2);
    run_instr(11'h550, 0, 0, -1, -1);
    for (int n = 0; n < 6; n++)
      run_instr(11'h0A0, 0, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller that turns the LEGv8 single-cycle datapath into a multicycle machine sharing one memory port between instruction fetch and data access. It decodes the latched opcode, steps the FETCH/DECODE/EXEC/MEM/WB state machine, and drives every datapath control line. It also runs the memory request/ready handshake, pulses PC update, and counts retired instructions. It sits beside the register file, ALU and sign extender and replaces the combinational `control` decoder.

## Interface
- Parameters:
- `CNT_W`, 32, width of retired-instruction counter
- Ports:
- `CLK`  in  1  clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high; takes effect on the next posedge
- `opcode`  in  11  instruction[31:21] from memory read data, valid when `mem_ready` is high in FETCH
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current request this cycle
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  write request (STUR)
- `mem_sel`  out  1  0 = address from PC, 1 = address from ALU result
- `irwrite`  out  1  latch instruction register
- `reg2loc`, `alusrc`, `mem2reg`, `regwrite`  out  1 each  datapath selects and enables
- `aluop`  out  4  AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111
- `signop`  out  2  01 D-type, 10 B-type, 11 CB-type
- `pcwrite`  out  1  load PC this cycle
- `pcsrc`  out  1  0 = PC+4, 1 = branch target
- `illegal`  out  1  sticky; unrecognised opcode trapped
- `instret`  out  CNT_W  retired-instruction count

## Operation
- Decode classes on opcode: LDUR 7C2, STUR 7C0, ADD 458, SUB 658, AND 450, ORR 550, CBZ opcode[10:3]=B4, B opcode[10:5]=05; all others are illegal.
- The block keeps its own copy of the opcode class, captured on the FETCH handshake. Controls after FETCH depend only on state plus that class (Moore).
- FETCH: `mem_req`=1, `mem_sel`=0. When `mem_ready`: `irwrite`=1, latch class, go to DECODE, or to TRAP if illegal.
- DECODE: register read. `reg2loc`=1 for STUR/CBZ; `signop` set by class. Next state is EXEC.
- EXEC:
  - R-type: `alusrc`=0, `aluop` by class, next WB.
  - LDUR/STUR: `alusrc`=1, ADD, next MEM.
  - CBZ: PASSB, `pcwrite`=1, `pcsrc`=`zero`, retire, next FETCH.
  - B: `pcwrite`=1, `pcsrc`=1, retire, next FETCH.
- MEM: `mem_req`=1, `mem_sel`=1, `mem_we`=1 for STUR. Waits while `mem_ready`=0 with all outputs stable. On ready: LDUR goes to WB; STUR asserts `pcwrite`=1, `pcsrc`=0, retires, and goes to FETCH.
- WB: `regwrite`=1, `mem2reg`=1 for LDUR; `pcwrite`=1, `pcsrc`=0, retire, next FETCH.
- TRAP: all enables 0, `illegal`=1, stays until `reset`.
- Retire means `instret` += 1 in the same cycle as `pcwrite`. It wraps modulo 2^CNT_W.
- `regwrite`, `mem_we` and `pcwrite` are never asserted in FETCH or DECODE.

## Timing
- Reset: state FETCH; `instret`=0 and `illegal`=0. Every output is 0 in the reset cycle. `mem_req` rises the first cycle after reset deasserts.
- Reset mid-instruction, including during a memory wait, abandons the instruction immediately. There is no retire and no write.
- Minimum cycles with `mem_ready` tied 1:
  - B and CBZ: 3
  - STUR and R-type: 4
  - LDUR: 5
- Each cycle of `mem_ready`=0 adds one cycle in FETCH or MEM.
- `mem_ready` outside FETCH/MEM is ignored. `mem_req` never drops before `mem_ready` is seen.
- Outputs are combinational from registered state and class only, except `pcsrc` in CBZ EXEC, which follows `zero` combinationally.

## Structure
- Package `legv8_pkg`:
  - opcode constants
  - `aluop` and `signop` encodings
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - opcode class enum (RTYPE, LOAD, STORE, CBZ, BR, ILL)
- Sub-module `opcode_classify` maps 11-bit opcode to class plus ALU op. It is purely combinational and is reused by the single-cycle `control`.
- State register, class register and counter stay in `multicycle_ctrl`.

## Test plan
- Reset, then ADD (458) with `mem_ready`=1. Expected: FETCH,DECODE,EXEC,WB; `aluop`=0010 in EXEC; `regwrite`+`pcwrite` in cycle 4; `instret`=1.
- LDUR (7C2) with `mem_ready` low for 3 cycles in MEM. Expected: `mem_req`=1, `mem_sel`=1, `mem_we`=0 held for 4 cycles, then WB with `mem2reg`=1; 8 cycles total.
- CBZ with `zero`=1, then `zero`=0. Expected: `pcwrite` in cycle 3 with `pcsrc`=1, then 0; `reg2loc`=1 and `signop`=11 in DECODE.
- STUR (7C0). Expected: `mem_we`=1 in MEM; `regwrite` never set; retire on the ready cycle.
- Opcode 000. Expected: TRAP, `illegal`=1 indefinitely, `instret` unchanged; `reset` clears `illegal` and returns to FETCH.
- `reset` during a MEM wait. Expected: next cycle state FETCH, no `pcwrite`, `instret`=0. Also preload `instret`=2^32-1 and retire once; expected `instret` wraps to 0.
